// File: rtl/pool2_f2_writer_pkg.sv
// Shared definitions for the pool2 -> f2_ram writer: lane geometry,
// RAM address width and the frame control state encoding.
package pool2_f2_writer_pkg;

  localparam int LANES  = 6;
  localparam int LANE_W = 16;
  localparam int WORD_W = LANES * LANE_W;
  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pool2_f2_writer_pool_max_lanes.sv
// Lane-wise signed maximum of two packed 6x16-bit words.
// Ties return b, which is bit-identical to a in that case.
module pool_max_lanes
  import pool2_f2_writer_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] y
);

  // Each lane is compared as a two's-complement value independently.
  always_comb begin
    y = '0;
    for (int k = 0; k < LANES; k++) begin
      y[k*LANE_W +: LANE_W] =
        ($signed(a[k*LANE_W +: LANE_W]) > $signed(b[k*LANE_W +: LANE_W])) ?
        a[k*LANE_W +: LANE_W] : b[k*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/pool2_f2_writer.sv
// 2x2 stride-2 max pooling of the conv2 output stream, writing one pooled
// 6-lane word per window into f2_ram. Even rows build half-window maxima in a
// line buffer; odd rows fold them with the current pair to finish windows.
module pool2_f2_writer
  import pool2_f2_writer_pkg::*;
#(
  parameter int MAP_W     = 10,
  parameter int MAP_H     = 10,
  parameter int N_GROUPS  = 3,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              conv_valid,
  input  logic [WORD_W-1:0] conv_data,
  output logic              conv_ready,
  output logic [WORD_W-1:0] f2_wdata,
  output logic              f2_wr_en,
  output logic [ADDR_W-1:0] f2_waddr,
  output logic              busy,
  output logic              done
);

  localparam int HALF_W    = MAP_W / 2;
  localparam int HALF_H    = MAP_H / 2;
  localparam int GRP_WORDS = HALF_W * HALF_H;
  localparam int COL_W     = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int ROW_W     = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int GRP_W     = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int LB_W      = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [GRP_W-1:0]   grp;

  logic [WORD_W-1:0]  pair_q;
  logic [WORD_W-1:0]  line_buf [HALF_W];

  logic               beat_fire;
  logic               last_col;
  logic               last_row;
  logic               last_grp;
  logic               win_done;
  logic               final_beat;
  logic [LB_W-1:0]    lb_idx;
  logic [WORD_W-1:0]  lb_rd;
  logic [WORD_W-1:0]  max_lb;
  logic [WORD_W-1:0]  max_pair;
  logic [ADDR_W-1:0]  addr_next;

  assign beat_fire  = conv_valid & conv_ready;
  assign last_col   = (col == COL_W'(MAP_W - 1));
  assign last_row   = (row == ROW_W'(MAP_H - 1));
  assign last_grp   = (grp == GRP_W'(N_GROUPS - 1));
  assign win_done   = beat_fire & row[0] & col[0];
  assign final_beat = beat_fire & last_col & last_row & last_grp;
  assign lb_idx     = LB_W'(col >> 1);
  assign lb_rd      = line_buf[lb_idx];

  pool_max_lanes u_max_lb (
    .a (lb_rd),
    .b (conv_data),
    .y (max_lb)
  );

  pool_max_lanes u_max_pair (
    .a (pair_q),
    .b (conv_data),
    .y (max_pair)
  );

  // Output word address; arithmetic is modulo 2^ADDR_W so it wraps naturally.
  always_comb begin
    addr_next = ADDR_W'(BASE_ADDR)
              + ADDR_W'(grp) * ADDR_W'(GRP_WORDS)
              + ADDR_W'(row >> 1) * ADDR_W'(HALF_W)
              + ADDR_W'(col >> 1);
  end

  // Pooling storage: always written before being read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      if (!row[0]) begin
        if (!col[0]) pair_q <= conv_data;
        else         line_buf[lb_idx] <= max_pair;
      end else if (!col[0]) begin
        pair_q <= max_lb;
      end
    end
  end

  // Frame control, raster counters and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      grp        <= '0;
      conv_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      f2_wr_en   <= 1'b0;
      f2_waddr   <= '0;
      f2_wdata   <= '0;
    end else begin
      f2_wr_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            conv_ready <= 1'b1;
            busy       <= 1'b1;
            col        <= '0;
            row        <= '0;
            grp        <= '0;
          end
        end
        RUN: begin
          if (beat_fire) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) begin
              row <= last_row ? '0 : row + 1'b1;
              if (last_row) grp <= last_grp ? '0 : grp + 1'b1;
            end
            if (win_done) begin
              f2_wr_en <= 1'b1;
              f2_wdata <= max_pair;
              f2_waddr <= addr_next;
            end
            if (final_beat) begin
              state      <= DONE;
              conv_ready <= 1'b0;
              busy       <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool2_f2_writer.sv
// Randomized scoreboard bench for pool2_f2_writer. Two instances share the
// input stream: one at BASE_ADDR 0, one at BASE_ADDR 1000 (address wrap).
module tb_pool2_f2_writer;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int G  = 3;
  localparam int NB = W * H * G;
  localparam int NW = (W / 2) * (H / 2) * G;

  typedef struct packed {
    logic [9:0]  addr;
    logic [95:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        conv_valid = 1'b0;
  logic [95:0] conv_data = '0;

  logic        ready_a, wr_a, busy_a, done_a;
  logic [95:0] wdata_a;
  logic [9:0]  waddr_a;
  logic        ready_b, wr_b, busy_b, done_b;
  logic [95:0] wdata_b;
  logic [9:0]  waddr_b;

  int   checks = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit   done_due [2];
  int   writes_seen [2];
  bit   done_seen = 1'b0;
  logic [95:0] frame [NB];

  always #5 clk = ~clk;

  pool2_f2_writer #(.MAP_W(W), .MAP_H(H), .N_GROUPS(G), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .conv_valid(conv_valid),
    .conv_data(conv_data), .conv_ready(ready_a), .f2_wdata(wdata_a),
    .f2_wr_en(wr_a), .f2_waddr(waddr_a), .busy(busy_a), .done(done_a));

  pool2_f2_writer #(.MAP_W(W), .MAP_H(H), .N_GROUPS(G), .BASE_ADDR(1000)) dut_b (
    .clk(clk), .rst(rst), .start(start), .conv_valid(conv_valid),
    .conv_data(conv_data), .conv_ready(ready_b), .f2_wdata(wdata_b),
    .f2_wr_en(wr_b), .f2_waddr(waddr_b), .busy(busy_b), .done(done_b));

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] max4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
    int m;
    m = $signed(a);
    if (int'($signed(b)) > m) m = $signed(b);
    if (int'($signed(c)) > m) m = $signed(c);
    if (int'($signed(d)) > m) m = $signed(d);
    return m[15:0];
  endfunction

  // Monitor for one instance: done must follow the frame's last write by one cycle.
  task automatic monitorInst(input int inst, input logic wr, input logic [9:0] addr,
                             input logic [95:0] data, input logic dn);
    exp_t e;
    bit   have;
    if (dn || done_due[inst])
      checkOutput($sformatf("done_%0d", inst), 96'(dn), 96'(done_due[inst]));
    done_due[inst] = 1'b0;
    if (dn && inst == 0) done_seen = 1'b1;
    if (wr) begin
      writes_seen[inst]++;
      have = (inst == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
      if (!have) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write_%0d actual_addr=%0d required=none", inst, addr);
      end else begin
        e = (inst == 0) ? q_a.pop_front() : q_b.pop_front();
        checkOutput($sformatf("waddr_%0d", inst), 96'(addr), 96'(e.addr));
        checkOutput($sformatf("wdata_%0d@%0d", inst, e.addr), data, e.data);
        if (e.last) done_due[inst] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    monitorInst(0, wr_a, waddr_a, wdata_a, done_a);
    monitorInst(1, wr_b, waddr_b, wdata_b, done_b);
  end

  // Reference: every 2x2 window of the stored frame, lane-wise signed max.
  task automatic buildExpected();
    exp_t e;
    int   idx;
    int   p;
    for (int g = 0; g < G; g++)
      for (int wr = 0; wr < H / 2; wr++)
        for (int wc = 0; wc < W / 2; wc++) begin
          idx = g * (W / 2) * (H / 2) + wr * (W / 2) + wc;
          p = g * W * H + 2 * wr * W + 2 * wc;
          for (int k = 0; k < 6; k++)
            e.data[k*16 +: 16] = max4(frame[p][k*16 +: 16], frame[p+1][k*16 +: 16],
                                      frame[p+W][k*16 +: 16], frame[p+W+1][k*16 +: 16]);
          e.last = (idx == NW - 1);
          e.addr = 10'(idx);
          q_a.push_back(e);
          e.addr = 10'((1000 + idx) % 1024);
          q_b.push_back(e);
        end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b0;
    conv_valid = 1'b0;
    q_a.delete();
    q_b.delete();
    done_due[0] = 1'b0;
    done_due[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 96'(ready_a), 96'(0));
    checkOutput("rst_busy", 96'(busy_a), 96'(0));
    checkOutput("rst_wr_en", 96'(wr_a), 96'(0));
    checkOutput("rst_done", 96'(done_a), 96'(0));
    checkOutput("rst_waddr", 96'(waddr_a), 96'(0));
    checkOutput("rst_wdata", wdata_a, 96'(0));
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // gap_mode: 0 continuous, 1 alternate valid/idle, 2 random idle gaps.
  task automatic driveFrame(input int n_beats, input int gap_mode, input int mid_start_at);
    bit acc;
    int budget;
    for (int i = 0; i < n_beats; i++) begin
      conv_valid = 1'b1;
      conv_data  = frame[i];
      start      = (i == mid_start_at);
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = ready_a;
        @(posedge clk);
        #1;
        start = 1'b0;
        budget++;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("[TB] FAIL beat_accept_timeout actual=not_ready required=ready beat=%0d", i);
        conv_valid = 1'b0;
        return;
      end
      conv_valid = 1'b0;
      conv_data  = {$urandom, $urandom, $urandom};
      if (gap_mode == 1) begin
        @(posedge clk);
        #1;
      end else if (gap_mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // Build a frame (mode 0: all 1, 1: random, 2/3: random with window 0 lane 0 edge values).
  task automatic makeFrame(input int mode);
    for (int i = 0; i < NB; i++)
      frame[i] = (mode == 0) ? {6{16'h0001}} : {$urandom, $urandom, $urandom};
    if (mode == 2) begin
      frame[0][15:0] = 16'hFFFB;
      frame[1][15:0] = 16'h0003;
      frame[W][15:0] = 16'hFFFF;
      frame[W+1][15:0] = 16'h0007;
    end else if (mode == 3) begin
      frame[0][15:0] = 16'h8000;
      frame[1][15:0] = 16'hFFFF;
      frame[W][15:0] = 16'h8001;
      frame[W+1][15:0] = 16'h8000;
    end
  endtask

  task automatic applyStimulus(input int mode, input int gap_mode, input int mid_start_at);
    int c;
    makeFrame(mode);
    buildExpected();
    writes_seen[0] = 0;
    writes_seen[1] = 0;
    done_seen = 1'b0;
    @(posedge clk);
    #1 conv_valid = 1'b1;
    conv_data = {$urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1 conv_valid = 1'b0;
    pulseStart();
    driveFrame(NB, gap_mode, mid_start_at);
    c = 0;
    while (!done_seen && c < 50) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    checkOutput("done_seen", 96'(done_seen), 96'(1));
    checkOutput("write_count_a", 96'(writes_seen[0]), 96'(NW));
    checkOutput("write_count_b", 96'(writes_seen[1]), 96'(NW));
    checkOutput("pending_a", 96'(q_a.size()), 96'(0));
    checkOutput("pending_b", 96'(q_b.size()), 96'(0));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    done_due[0] = 1'b0;
    done_due[1] = 1'b0;
    writes_seen[0] = 0;
    writes_seen[1] = 0;
    doReset();
    applyStimulus(0, 0, -1);
    applyStimulus(2, 0, -1);
    applyStimulus(3, 0, -1);
    applyStimulus(1, 1, -1);
    applyStimulus(1, 2, 100);
    // Abort a frame halfway, then a clean frame must produce each address once.
    makeFrame(1);
    buildExpected();
    pulseStart();
    driveFrame(NB / 2, 0, -1);
    doReset();
    repeat (10) @(posedge clk);
    applyStimulus(1, 0, -1);
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool2_f2_writer.md
POOL2_F2_WRITER -- requirements
Module: pool2_f2_writer

Interface
REQ-001 Parameter MAP_W, default 10: conv2 output map width in beats.
REQ-002 Parameter MAP_H, default 10: conv2 output map height in rows.
REQ-003 Parameter N_GROUPS, default 3: number of 6-lane channel groups per frame.
REQ-004 Parameter BASE_ADDR, default 0: first f2_ram word address written.
REQ-005 clk  input  1: single clock, all logic on its rising edge.
REQ-006 rst  input  1: reset, asynchronous, active-high.
REQ-007 start  input  1: one-cycle pulse, begins a frame.
REQ-008 conv_valid  input  1: conv_data carries a valid beat this cycle.
REQ-009 conv_data  input  96: 6 lanes, each a signed 16-bit value; lane k occupies bits [16k+15:16k].
REQ-010 conv_ready  output  1: high only in RUN; a beat transfers when conv_valid and conv_ready are both high.
REQ-011 f2_wdata  output  96: pooled word, same lane layout as conv_data.
REQ-012 f2_wr_en  output  1: one-cycle write strobe to f2_ram.
REQ-013 f2_waddr  output  10: f2_ram write address.
REQ-014 busy  output  1: high in RUN.
REQ-015 done  output  1: one-cycle pulse when the last pooled word has been written.

Function
REQ-016 State machine states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE the cycle the final window completes; DONE->IDLE unconditionally after one cycle.
REQ-017 start while in RUN or DONE is ignored; conv_valid outside RUN is ignored and consumes no beat.
REQ-018 Input order: raster within a group (col fastest, then row), groups consecutive; counters col 0..MAP_W-1, row 0..MAP_H-1, grp 0..N_GROUPS-1; col and row wrap to 0; grp increments on row wrap.
REQ-019 Pooling is 2x2, stride 2, lane-wise signed max; no ReLU, no saturation, width unchanged.
REQ-020 Even row, even col: hold beat in a pair register; even row, odd col: store max(pair, beat) into line buffer entry col/2 (MAP_W/2 entries x 96 bits).
REQ-021 Odd row, even col: pair register = max(linebuf[col/2], beat); odd row, odd col: window result = max(pair, beat).
REQ-022 Window result is registered: f2_wr_en, f2_wdata and f2_waddr are valid in the cycle after the completing beat (latency 1).
REQ-023 f2_waddr = BASE_ADDR + grp*(MAP_W/2)*(MAP_H/2) + (row/2)*(MAP_W/2) + col/2, truncated to 10 bits.
REQ-024 Signed comparison: 16'h8000 < 16'hFFFF < 16'h0000 < 16'h7FFF; ties choose either operand (identical values).
REQ-025 done asserts the cycle after the final f2_wr_en (frame of N_GROUPS*(MAP_W/2)*(MAP_H/2) words).
REQ-026 Beats with gaps (conv_valid low) stall counters and datapath; no write is produced without a completing beat.
REQ-027 MAP_W and MAP_H are even; odd values are unsupported.

Reset
REQ-028 rst asserted at any time (including mid-frame) forces IDLE; conv_ready, f2_wr_en, busy, done = 0; f2_waddr = 0; f2_wdata = 0; counters = 0.
REQ-029 Line buffer and pair register contents are not reset; they are always overwritten before use.
REQ-030 After rst deasserts, a new start begins a clean frame; no write from the aborted frame is emitted.

Structure
REQ-031 Shared package holds LANES=6, LANE_W=16, WORD_W=96, ADDR_W=10 and the state enum.
REQ-032 One sub-module, pool_max_lanes: combinational 6-lane signed 16-bit max of two 96-bit words, instantiated twice (line-buffer path, pair path).

Verification
REQ-033 Reset, start, 300 beats all lanes = 16'h0001 -> 75 writes, addresses 0..74 in order, all data 96'h0001 per lane, done 1 cycle after write 75.
REQ-034 Group 0 window (0,0) beats lane0 = -5, 3, -1, 7 (positions r0c0, r0c1, r1c0, r1c1) -> first write addr 0, lane0 = 7; repeat with 16'h8000, 16'hFFFF, 16'h8001, 16'h8000 -> lane0 = 16'hFFFF.
REQ-035 conv_valid toggling 1/0 every cycle across a frame -> same 75 writes and data as continuous input; no extra strobes.
REQ-036 rst pulsed after 150 beats, then new start with 300 beats -> no write between rst and new start; new frame yields addresses 0..74 exactly once.
REQ-037 BASE_ADDR=1000, N_GROUPS=3 -> addresses 1000..1023 then wrap to 0..50; start pulsed mid-frame -> ignored, write count unchanged.
